rxrbcnt_sfifo: RTL and testbench
================================

// Module: rxrbcnt_sfifo
// PURPOSE
//  Single-clock, parametrised successor to the RX byte-count FIFO. Buffers per-frame
//  byte-count/status words between the RX MAC datapath and the AXIS bridge read-out logic.
//  Adds selectable first-word-fall-through (FWFT) mode, programmable almost-full and
//  almost-empty thresholds, and sticky overflow/underflow error flags.
// PARAMETERS
//  WIDTH      64   data word width in bits
//  DEPTH      256  number of storage words; must equal 2**PTR
//  PTR        8    address width, log2(DEPTH)
//  FWFT       0    0 = standard read (data 1 cycle after rden); 1 = head word pre-presented on dataout
//  AF_THRESH  240  afull asserts when usedw >= AF_THRESH; legal range 1..DEPTH
//  AE_THRESH  8    aempty asserts when usedw <= AE_THRESH; legal range 0..DEPTH-1
// PORTS
//  clk       in   1        single clock for all logic
//  reset     in   1        synchronous reset, active-high
//  wren      in   1        write request
//  datain    in   WIDTH    write data
//  full      out  1        usedw == DEPTH
//  afull     out  1        usedw >= AF_THRESH
//  rden      in   1        read request (standard mode) / pop acknowledge (FWFT mode)
//  dataout   out  WIDTH    read data
//  rdvalid   out  1        standard: pulses 1 cycle after an accepted read; FWFT: equals ~empty
//  empty     out  1        usedw == 0
//  aempty    out  1        usedw <= AE_THRESH
//  usedw     out  PTR+1    words held; FWFT count includes the presented head word
//  overflow  out  1        sticky: a write was attempted while full
//  underflow out  1        sticky: a read was attempted while empty
//  clr_err   in   1        clears overflow/underflow on the next edge
// BEHAVIOUR
//  - Reset (synchronous, active-high) forces: pointers=0, usedw=0, empty=1, aempty=1,
//    full=0, afull=0, dataout=0, rdvalid=0, overflow=0, underflow=0. Storage RAM is not cleared.
//  - reset overrides all other inputs in the same cycle. Any data in flight is discarded.
//  - Accept rules: write accepted iff wren & ~full. Read accepted iff rden & ~empty.
//  - Rejected write: dropped, no state change; sets overflow. Rejected read: no state change;
//    sets underflow.
//  - Simultaneous accepted read and write: usedw unchanged.
//  - When full, a write is rejected even if a read is accepted in the same cycle.
//  - When empty, a read is rejected even if a write is accepted in the same cycle.
//  - Pointers are PTR bits wide and wrap modulo DEPTH. usedw is a registered up/down counter of
//    width PTR+1, range 0..DEPTH, and never wraps.
//  - All status flags (full, afull, empty, aempty, usedw) are registered and reflect state after
//    the current edge.
//  - Write-to-flag latency: the edge that accepts a write updates usedw, empty and afull; those
//    values are visible in the following cycle.
//  - Standard mode (FWFT=0):
//    - Read accepted at edge N: dataout is registered and rdvalid=1 during cycle N+1.
//    - dataout holds its last value when no read is accepted; rdvalid=0 in that case.
//  - FWFT mode (FWFT=1):
//    - A head-output register holds the oldest word; dataout is valid whenever empty=0.
//    - A word written into an empty FIFO at edge N appears on dataout with empty=0 during cycle N+1.
//    - An accepted rden at edge N advances the head: the next word is on dataout during cycle N+1,
//      or empty=1 if none remains.
//    - Back-to-back rden drains one word per cycle with no bubbles.
//  - Error flags: set on a rejected access and stay set until clr_err or reset.
//    If clr_err coincides with a new error, the flag stays set.
//  - Throughput: one write and one read per cycle, sustained.
// TESTING
//  - Reset, then write 256 words 0..255 with no reads -> full=1 and usedw=256 after the last edge;
//    afull asserted from usedw=240; a 257th wren sets overflow=1 and usedw stays 256.
//  - FWFT=1: write 0xA5 into an empty FIFO -> dataout=0xA5, empty=0, usedw=1 in the next cycle;
//    rden for 1 cycle -> empty=1, usedw=0.
//  - FWFT=0: write 3 words, then pulse rden 3 times back-to-back -> rdvalid high for 3 cycles,
//    each starting 1 cycle after its rden, data in order; a 4th rden sets underflow=1.
//  - Fill to usedw=128, then assert wren and rden for 1000 cycles with an incrementing pattern ->
//    usedw constant at 128, data order preserved across pointer wrap, no error flags set.
//  - Full FIFO with wren & rden asserted together -> read accepted, write rejected, usedw=255,
//    overflow=1; then clr_err -> overflow=0 on the next edge.
//  - Assert reset in the middle of a burst at usedw=50 -> next cycle usedw=0, empty=1, aempty=1,
//    rdvalid=0, flags cleared; the first subsequent write reads back correctly.

Source files
------------

// File: rtl/rxrbcnt_sfifo.sv
// rxrbcnt_sfifo: single-clock byte-count/status FIFO with optional FWFT head
// register, almost-full/almost-empty thresholds and sticky error flags.
module rxrbcnt_sfifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 256,
  parameter int PTR       = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 240,
  parameter int AE_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  output logic             full,
  output logic             afull,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             rdvalid,
  output logic             empty,
  output logic             aempty,
  output logic [PTR:0]     usedw,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [PTR:0] CNT_MAX = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] CNT_ONE = (PTR+1)'(1);
  localparam logic [PTR:0] AF_LVL  = (PTR+1)'(AF_THRESH);
  localparam logic [PTR:0] AE_LVL  = (PTR+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR-1:0]   wptr_q, wptr_d;
  logic [PTR-1:0]   rptr_q, rptr_d;
  logic [PTR-1:0]   rptr_nx;
  logic [PTR:0]     cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             empty_q, empty_d;
  logic             aempty_q, aempty_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rdv_q, rdv_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Next-state: accept decisions, pointers, occupancy, flags, read data.
  always_comb begin
    wr_acc  = wren & ~full_q;
    rd_acc  = rden & ~empty_q;
    rptr_nx = rptr_q + PTR'(1);
    wptr_d  = wr_acc ? wptr_q + PTR'(1) : wptr_q;
    rptr_d  = rd_acc ? rptr_nx : rptr_q;
    cnt_d   = cnt_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    full_d   = (cnt_d == CNT_MAX);
    afull_d  = (cnt_d >= AF_LVL);
    empty_d  = (cnt_d == '0);
    aempty_d = (cnt_d <= AE_LVL);
    ovf_d    = (ovf_q & ~clr_err) | (wren & full_q);
    unf_d    = (unf_q & ~clr_err) | (rden & empty_q);
    dout_d   = dout_q;
    rdv_d    = 1'b0;
    if (FWFT == 0) begin
      rdv_d = rd_acc;
      if (rd_acc) dout_d = mem[rptr_q];
    end else begin
      // Head register always mirrors the oldest word; a word written while
      // the FIFO is (or becomes) empty bypasses the RAM straight into it.
      if (rd_acc) begin
        if (cnt_q > CNT_ONE) dout_d = mem[rptr_nx];
        else if (wr_acc)     dout_d = datain;
      end else if (wr_acc && cnt_q == '0) begin
        dout_d = datain;
      end
    end
  end

  // Storage write; RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wptr_q] <= datain;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      dout_q   <= '0;
      rdv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      dout_q   <= dout_d;
      rdv_q    <= rdv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign full      = full_q;
  assign afull     = afull_q;
  assign empty     = empty_q;
  assign aempty    = aempty_q;
  assign usedw     = cnt_q;
  assign dataout   = dout_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign rdvalid   = (FWFT != 0) ? ~empty_q : rdv_q;

endmodule

// File: tb/tb_rxrbcnt_sfifo.sv
// tb_rxrbcnt_sfifo: standard and FWFT instances share one stimulus stream;
// a queue-based reference model feeds a scoreboard checked at negedge.
module tb_rxrbcnt_sfifo;

  localparam int W   = 64;
  localparam int D   = 256;
  localparam int P   = 8;
  localparam int AF  = 240;
  localparam int AE  = 8;

  logic         clk = 1'b0;
  logic         reset, wren, rden, clr_err;
  logic [W-1:0] datain;

  logic         full_s, afull_s, empty_s, aempty_s, rdvalid_s, ovf_s, unf_s;
  logic [W-1:0] dout_s;
  logic [P:0]   usedw_s;
  logic         full_f, afull_f, empty_f, aempty_f, rdvalid_f, ovf_f, unf_f;
  logic [W-1:0] dout_f;
  logic [P:0]   usedw_f;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mdl[$];
  logic [W-1:0] exp_s[$];
  bit m_ovf, m_unf, m_rdv;

  always #5 clk = ~clk;

  rxrbcnt_sfifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(0),
                  .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .reset(reset), .wren(wren), .datain(datain),
    .full(full_s), .afull(afull_s), .rden(rden), .dataout(dout_s),
    .rdvalid(rdvalid_s), .empty(empty_s), .aempty(aempty_s),
    .usedw(usedw_s), .overflow(ovf_s), .underflow(unf_s),
    .clr_err(clr_err));

  rxrbcnt_sfifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .FWFT(1),
                  .AF_THRESH(AF), .AE_THRESH(AE)) u_fw (
    .clk(clk), .reset(reset), .wren(wren), .datain(datain),
    .full(full_f), .afull(afull_f), .rden(rden), .dataout(dout_f),
    .rdvalid(rdvalid_f), .empty(empty_f), .aempty(aempty_f),
    .usedw(usedw_f), .overflow(ovf_f), .underflow(unf_f),
    .clr_err(clr_err));

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics sampled on each rising edge.
  always @(posedge clk) begin
    int sz;
    bit wa, ra;
    logic [W-1:0] v;
    if (reset) begin
      mdl.delete();
      exp_s.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rdv = 1'b0;
    end else begin
      sz = mdl.size();
      wa = wren && (sz < D);
      ra = rden && (sz > 0);
      m_ovf = (m_ovf && !clr_err) || (wren && sz == D);
      m_unf = (m_unf && !clr_err) || (rden && sz == 0);
      m_rdv = ra;
      if (ra) begin
        v = mdl.pop_front();
        exp_s.push_back(v);
      end
      if (wa) mdl.push_back(datain);
    end
  end

  // Monitor: status of both instances plus scoreboard pops on output.
  always @(negedge clk) begin
    int sz;
    logic [W-1:0] e;
    if (chk_en) begin
      sz = mdl.size();
      chk("usedw_s",  W'(usedw_s), W'(sz));
      chk("usedw_f",  W'(usedw_f), W'(sz));
      chk("full_s",   W'(full_s),   W'(sz == D));
      chk("full_f",   W'(full_f),   W'(sz == D));
      chk("afull_s",  W'(afull_s),  W'(sz >= AF));
      chk("afull_f",  W'(afull_f),  W'(sz >= AF));
      chk("empty_s",  W'(empty_s),  W'(sz == 0));
      chk("empty_f",  W'(empty_f),  W'(sz == 0));
      chk("aempty_s", W'(aempty_s), W'(sz <= AE));
      chk("aempty_f", W'(aempty_f), W'(sz <= AE));
      chk("ovf_s",    W'(ovf_s),    W'(m_ovf));
      chk("ovf_f",    W'(ovf_f),    W'(m_ovf));
      chk("unf_s",    W'(unf_s),    W'(m_unf));
      chk("unf_f",    W'(unf_f),    W'(m_unf));
      chk("rdvalid_s", W'(rdvalid_s), W'(m_rdv));
      chk("rdvalid_f", W'(rdvalid_f), W'(sz != 0));
      if (rdvalid_s) begin
        if (exp_s.size() == 0) begin
          chk("sb_nonempty", W'(0), W'(1));
        end else begin
          e = exp_s.pop_front();
          chk("data_s", dout_s, e);
        end
      end
      if (sz != 0) chk("head_f", dout_f, mdl[0]);
    end
  end

  task automatic step(input bit w, input bit r, input logic [W-1:0] d,
                      input bit c, input bit rst);
    wren = w; rden = r; datain = d; clr_err = c; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  initial begin
    int bias_w, bias_r;
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    chk_en = 1'b1;
    chk("rst_dout_s", dout_s, '0);
    chk("rst_dout_f", dout_f, '0);
    chk("rst_usedw", W'(usedw_s), '0);

    // Fill to full with 0..255, then one rejected write.
    for (int i = 0; i < D; i++) begin
      step(1, 0, W'(i), 0, 0);
      if (i == AF - 2) chk("afull_239", W'(afull_s), '0);
      if (i == AF - 1) chk("afull_240", W'(afull_s), W'(1));
    end
    chk("fill_full", W'(full_s), W'(1));
    chk("fill_usedw", W'(usedw_s), W'(D));
    step(1, 0, 64'hDEAD, 0, 0);
    chk("ovf_set", W'(ovf_s), W'(1));
    chk("ovf_usedw", W'(usedw_s), W'(D));
    step(1, 1, 64'hBEEF, 0, 0);
    chk("full_rw_usedw", W'(usedw_s), W'(D - 1));
    chk("full_rw_ovf", W'(ovf_f), W'(1));
    step(0, 0, '0, 1, 0);
    chk("clr_ovf", W'(ovf_s), '0);

    // FWFT single word presentation and pop.
    step(0, 0, '0, 0, 1);
    step(1, 0, 64'hA5, 0, 0);
    chk("fwft_head", dout_f, 64'hA5);
    chk("fwft_empty", W'(empty_f), '0);
    step(0, 1, '0, 0, 0);
    chk("fwft_pop_empty", W'(empty_f), W'(1));
    chk("fwft_pop_usedw", W'(usedw_f), '0);

    // Standard mode three reads then underflow.
    step(0, 0, '0, 0, 1);
    step(1, 0, 64'h11, 0, 0);
    step(1, 0, 64'h22, 0, 0);
    step(1, 0, 64'h33, 0, 0);
    step(0, 1, '0, 0, 0);
    chk("std_rd1", dout_s, 64'h11);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    chk("std_rd3", dout_s, 64'h33);
    step(0, 1, '0, 0, 0);
    chk("std_unf", W'(unf_s), W'(1));
    chk("std_rdv_low", W'(rdvalid_s), '0);
    step(0, 0, '0, 1, 0);

    // Sustained read+write at half depth across pointer wrap.
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 128; i++) step(1, 0, W'(i), 0, 0);
    for (int i = 0; i < 1000; i++) step(1, 1, W'(128 + i), 0, 0);
    chk("stream_usedw", W'(usedw_s), W'(128));
    chk("stream_ovf", W'(ovf_s | unf_s | ovf_f | unf_f), '0);

    // Reset mid-burst at 50 words.
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 50; i++) step(1, 0, W'(1000 + i), 0, 0);
    step(1, 1, 64'h99, 0, 1);
    chk("mid_rst_usedw", W'(usedw_s), '0);
    chk("mid_rst_rdv", W'(rdvalid_s), '0);
    step(1, 0, 64'h77, 0, 0);
    chk("post_rst_head_f", dout_f, 64'h77);
    step(0, 1, '0, 0, 0);
    chk("post_rst_rd_s", dout_s, 64'h77);

    // Randomised traffic with shifting bias, occasional clr_err/reset.
    bias_w = 50;
    bias_r = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        bias_w = $urandom_range(10, 95);
        bias_r = $urandom_range(10, 95);
      end
      step($urandom_range(99) < bias_w, $urandom_range(99) < bias_r,
           {$urandom, $urandom}, $urandom_range(49) == 0,
           $urandom_range(799) == 0);
    end
    for (int i = 0; i < D + 2; i++) step(0, 1, '0, 0, 0);
    idle(3);
    chk("sb_drained", W'(exp_s.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
